// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK/CS/MOSI on CLK, deserialises MOSI into data_read
// and serialises a preloaded word onto MISO; config layout shared with the master.
module spi_slave #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              SCK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [15:0]       data_config,
  input  logic              config_enable,
  input  logic [DATA_W-1:0] data_send,
  input  logic              load_data,
  output logic [DATA_W-1:0] data_read,
  output logic              read_valid,
  output logic              busy,
  output logic              frame_error,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [8:0] LEN_MAX = 9'(DATA_W);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [15:0]       conf_r;
  logic [1:0]        sck_sync_r;
  logic [1:0]        cs_sync_r;
  logic [1:0]        mosi_sync_r;
  logic              sck_prev_r;
  logic              cs_act_prev_r;
  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] tx_hold_r;
  logic              tx_pending_r;
  logic [DATA_W-1:0] tx_word_r;
  logic [DATA_W-1:0] rx_word_r;

  logic              enable_s;
  logic              msb_s;
  logic              sck_s;
  logic              mosi_s;
  logic              lead_s;
  logic              trail_s;
  logic              cs_act_s;
  logic              start_s;
  logic [8:0]        len_s;
  logic [CNT_W-1:0]  n_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [IDX_W-1:0]  tx_idx_s;
  logic [IDX_W-1:0]  rx_idx_s;
  logic [IDX_W-1:0]  last_idx_s;
  logic [DATA_W-1:0] start_word_s;
  logic              first_bit_s;
  logic [DATA_W-1:0] rx_next_s;

  // Decode config, detect synchronised edges and compute next TX/RX bits
  always_comb begin
    enable_s   = conf_r[0];
    msb_s      = conf_r[2];
    sck_s      = sck_sync_r[1];
    mosi_s     = mosi_sync_r[1];
    cs_act_s   = (cs_sync_r[1] == conf_r[3]);
    len_s      = {1'b0, conf_r[15:8]} + 9'd1;
    if (len_s > LEN_MAX) begin
      n_s = CNT_W'(DATA_W);
    end else begin
      n_s = CNT_W'(len_s);
    end
    // CPOL=1 idles low, so the active pulse starts with a rising edge
    if (conf_r[1]) begin
      lead_s  = sck_s & ~sck_prev_r;
      trail_s = ~sck_s & sck_prev_r;
    end else begin
      lead_s  = ~sck_s & sck_prev_r;
      trail_s = sck_s & ~sck_prev_r;
    end
    start_s    = enable_s && (state_r == ST_IDLE) && cs_act_s && !cs_act_prev_r;
    cnt_next_s = cnt_r + CNT_W'(1);
    last_idx_s = IDX_W'(n_s - CNT_W'(1));
    rx_idx_s   = IDX_W'(cnt_r);
    if (msb_s) begin
      tx_idx_s = IDX_W'(n_s - CNT_W'(1) - cnt_r);
    end else begin
      tx_idx_s = IDX_W'(cnt_r);
    end
    if (tx_pending_r) begin
      start_word_s = tx_hold_r;
    end else begin
      start_word_s = {DATA_W{1'b1}};
    end
    if (msb_s) begin
      first_bit_s = start_word_s[last_idx_s];
    end else begin
      first_bit_s = start_word_s[0];
    end
    rx_next_s = rx_word_r;
    if (msb_s) begin
      rx_next_s = {rx_word_r[DATA_W-2:0], mosi_s};
    end else begin
      rx_next_s[rx_idx_s] = mosi_s;
    end
  end

  // Two-flop synchronisers plus previous-value flops for edge detection
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sck_sync_r    <= 2'b00;
      cs_sync_r     <= 2'b00;
      mosi_sync_r   <= 2'b00;
      sck_prev_r    <= 1'b0;
      cs_act_prev_r <= 1'b0;
    end else begin
      sck_sync_r    <= {sck_sync_r[0], SCK};
      cs_sync_r     <= {cs_sync_r[0], CS};
      mosi_sync_r   <= {mosi_sync_r[0], MOSI};
      sck_prev_r    <= sck_s;
      cs_act_prev_r <= cs_act_s;
    end
  end

  // Config register and TX holding register; a load coinciding with a start wins
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      conf_r       <= 16'h0000;
      tx_hold_r    <= {DATA_W{1'b0}};
      tx_pending_r <= 1'b0;
    end else begin
      if (config_enable && !busy) begin
        conf_r <= data_config;
      end
      if (load_data) begin
        tx_hold_r    <= data_send;
        tx_pending_r <= 1'b1;
      end else if (start_s) begin
        tx_pending_r <= 1'b0;
      end
    end
  end

  // Frame state machine with registered outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      tx_word_r   <= {DATA_W{1'b0}};
      rx_word_r   <= {DATA_W{1'b0}};
      MISO        <= 1'b1;
      data_read   <= {DATA_W{1'b0}};
      read_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      read_valid  <= 1'b0;
      frame_error <= 1'b0;
      tx_underrun <= 1'b0;
      if (!enable_s) begin
        state_r <= ST_IDLE;
        MISO    <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start_s) begin
              state_r     <= ST_ACTIVE;
              busy        <= 1'b1;
              cnt_r       <= {CNT_W{1'b0}};
              rx_word_r   <= {DATA_W{1'b0}};
              tx_word_r   <= start_word_s;
              tx_underrun <= ~tx_pending_r;
              MISO        <= first_bit_s;
            end else begin
              MISO <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (!cs_act_s) begin
              frame_error <= 1'b1;
              MISO        <= 1'b1;
              busy        <= 1'b0;
              state_r     <= ST_IDLE;
            end else if (lead_s) begin
              rx_word_r <= rx_next_s;
              cnt_r     <= cnt_next_s;
              if (cnt_next_s == n_s) begin
                data_read  <= rx_next_s;
                read_valid <= 1'b1;
                MISO       <= 1'b1;
                state_r    <= ST_DONE;
              end
            end else if (trail_s && (cnt_r != {CNT_W{1'b0}}) && (cnt_r < n_s)) begin
              MISO <= tx_word_r[tx_idx_s];
            end
          end
          ST_DONE: begin
            MISO <= 1'b1;
            if (!cs_act_s) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            MISO    <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI master plus a word-level reference model.
module tb_spi_slave;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          sck, cs, mosi, miso;
  logic [15:0]   data_config;
  logic          config_enable, load_data;
  logic [DW-1:0] data_send, data_read;
  logic          read_valid, busy, frame_error, tx_underrun;

  int checks = 0;
  int failures = 0;
  int rv_cnt, fe_cnt, ur_cnt;
  logic busy_seen;

  // Reference model state: word-level view of the responder
  logic [15:0]   m_conf;
  logic          m_pending;
  logic [DW-1:0] m_hold, m_read;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(DW)) dut (
    .CLK(clk), .reset(reset), .SCK(sck), .CS(cs), .MOSI(mosi), .MISO(miso),
    .data_config(data_config), .config_enable(config_enable),
    .data_send(data_send), .load_data(load_data), .data_read(data_read),
    .read_valid(read_valid), .busy(busy), .frame_error(frame_error),
    .tx_underrun(tx_underrun)
  );

  // Count pulse cycles away from the active edge
  always @(negedge clk) begin
    if (read_valid === 1'b1) rv_cnt = rv_cnt + 1;
    if (frame_error === 1'b1) fe_cnt = fe_cnt + 1;
    if (tx_underrun === 1'b1) ur_cnt = ur_cnt + 1;
  end

  function automatic int n_of(input logic [15:0] c);
    int n;
    n = int'(c[15:8]) + 1;
    return (n > DW) ? DW : n;
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    logic [31:0] one;
    one = 32'h0000_0001;
    return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'h0000_0001);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt;
    rv_cnt = 0; fe_cnt = 0; ur_cnt = 0;
  endtask

  // Write with enable low first so pin idle levels can settle for the new polarity
  task automatic write_conf(input logic [15:0] c);
    data_config = c & 16'hFFFE;
    config_enable = 1'b1; tick(1); config_enable = 1'b0;
    sck = c[1] ? 1'b0 : 1'b1;
    cs = c[3] ? 1'b0 : 1'b1;
    mosi = 1'b0;
    tick(5);
    data_config = c;
    config_enable = 1'b1; tick(1); config_enable = 1'b0;
    tick(5);
    m_conf = c;
  endtask

  task automatic load_word(input logic [31:0] d);
    data_send = d; load_data = 1'b1; tick(1); load_data = 1'b0;
    m_hold = d; m_pending = 1'b1;
  endtask

  task automatic model_start(output logic [31:0] tx, output logic ur);
    tx = m_pending ? m_hold : 32'hFFFF_FFFF;
    ur = !m_pending;
    m_pending = 1'b0;
  endtask

  // Bit-level master. abort_kind 1 releases CS at abort_at; 2 raises reset there and returns with it high.
  task automatic run_frame(input int nbits, input logic [31:0] word, input int abort_at,
                           input int abort_kind, input int mid_at, input logic [15:0] mid_conf,
                           output logic [31:0] rx);
    logic msb, lead, act;
    bit aborted;
    msb = m_conf[2]; lead = m_conf[1]; act = m_conf[3];
    rx = 32'h0; aborted = 1'b0; busy_seen = 1'b0;
    cs = act;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        aborted = 1'b1;
        if (abort_kind == 1) begin
          cs = ~act; tick(8);
        end else begin
          reset = 1'b1; #1;
        end
        break;
      end
      if (i == mid_at) begin
        data_config = mid_conf; config_enable = 1'b1; tick(1); config_enable = 1'b0;
      end
      mosi = msb ? word[nbits-1-i] : word[i];
      tick(1);
      if (msb) rx[nbits-1-i] = miso; else rx[i] = miso;
      sck = lead; tick(5);
      sck = ~lead; tick(4);
    end
    if (!aborted) begin
      busy_seen = busy;
      cs = ~act;
      tick(8);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(2);
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", miso); end
    checks++; if (data_read !== 32'h0) begin failures++; $display("FAIL reset_data_read got=%h exp=0", data_read); end
    checks++; if ({read_valid, busy, frame_error, tx_underrun} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {read_valid, busy, frame_error, tx_underrun});
    end
    reset = 1'b0; tick(2);
    m_conf = 16'h0; m_pending = 1'b0; m_hold = 32'h0; m_read = 32'h0;
  endtask

  task automatic test_msb_first;
    logic [31:0] exp_tx, got; logic exp_ur;
    write_conf(16'h0F07); load_word(32'h0000A55A); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(16, 32'h0000_1234, -1, 0, -1, 16'h0000, got);
    m_read = 32'h0000_1234 & mask_of(16);
    checks++; if ((got & mask_of(16)) !== (exp_tx & mask_of(16))) begin failures++; $display("FAIL msb_miso got=%h exp=%h", got, exp_tx & mask_of(16)); end
    checks++; if (data_read !== m_read) begin failures++; $display("FAIL msb_data_read got=%h exp=%h", data_read, m_read); end
    checks++; if (rv_cnt !== 1) begin failures++; $display("FAIL msb_read_valid got=%0d exp=1", rv_cnt); end
    checks++; if (busy_seen !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL msb_busy got=%b%b exp=10", busy_seen, busy); end
    checks++; if (ur_cnt !== 0) begin failures++; $display("FAIL msb_underrun got=%0d exp=0", ur_cnt); end
  endtask

  task automatic test_lsb_first;
    logic [31:0] exp_tx, got; logic exp_ur;
    write_conf(16'h0703); load_word(32'h0000_0081); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(8, 32'h0000_00C3, -1, 0, -1, 16'h0000, got);
    m_read = 32'h0000_00C3;
    checks++; if ((got & mask_of(8)) !== (exp_tx & mask_of(8))) begin failures++; $display("FAIL lsb_miso got=%h exp=%h", got, exp_tx & mask_of(8)); end
    checks++; if (data_read !== m_read) begin failures++; $display("FAIL lsb_data_read got=%h exp=%h", data_read, m_read); end
    checks++; if (rv_cnt !== 1) begin failures++; $display("FAIL lsb_read_valid got=%0d exp=1", rv_cnt); end
  endtask

  task automatic test_underrun;
    logic [31:0] exp_tx, got; logic exp_ur;
    write_conf(16'h0F07); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(16, 32'h0000_5A0F, -1, 0, -1, 16'h0000, got);
    m_read = 32'h0000_5A0F;
    checks++; if ((got & mask_of(16)) !== (exp_tx & mask_of(16))) begin failures++; $display("FAIL underrun_miso got=%h exp=%h", got, exp_tx & mask_of(16)); end
    checks++; if (ur_cnt !== int'(exp_ur)) begin failures++; $display("FAIL underrun_pulse got=%0d exp=%0d", ur_cnt, exp_ur); end
    checks++; if (data_read !== m_read || rv_cnt !== 1) begin failures++; $display("FAIL underrun_rx got=%h/%0d exp=%h/1", data_read, rv_cnt, m_read); end
  endtask

  task automatic test_frame_error;
    logic [31:0] exp_tx, got; logic exp_ur;
    load_word(32'h0000_3C3C); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(16, 32'h0000_BEEF, 5, 1, -1, 16'h0000, got);
    checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt); end
    checks++; if (rv_cnt !== 0) begin failures++; $display("FAIL ferr_read_valid got=%0d exp=0", rv_cnt); end
    checks++; if (data_read !== m_read || busy !== 1'b0 || miso !== 1'b1) begin
      failures++; $display("FAIL ferr_hold got=%h busy=%b miso=%b exp=%h busy=0 miso=1", data_read, busy, miso, m_read);
    end
    load_word(32'h0000_C001); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(16, 32'h0000_7E81, -1, 0, -1, 16'h0000, got);
    m_read = 32'h0000_7E81;
    checks++; if (data_read !== m_read || rv_cnt !== 1 || fe_cnt !== 0) begin failures++; $display("FAIL ferr_next got=%h/%0d exp=%h/1", data_read, rv_cnt, m_read); end
    checks++; if ((got & mask_of(16)) !== (exp_tx & mask_of(16))) begin failures++; $display("FAIL ferr_next_miso got=%h exp=%h", got, exp_tx & mask_of(16)); end
  endtask

  task automatic test_conf_busy;
    logic [31:0] exp_tx, got; logic exp_ur;
    load_word(32'h0000_1357); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(16, 32'h0000_9AC5, -1, 0, 3, 16'h0707, got);
    m_read = 32'h0000_9AC5;
    checks++; if (data_read !== m_read || rv_cnt !== 1) begin failures++; $display("FAIL busy_conf_drop got=%h/%0d exp=%h/1", data_read, rv_cnt, m_read); end
    write_conf(16'h0707); load_word(32'h0000_00E4); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(8, 32'h0000_005B, -1, 0, -1, 16'h0000, got);
    m_read = 32'h0000_005B;
    checks++; if (data_read !== m_read || rv_cnt !== 1) begin failures++; $display("FAIL busy_conf_apply got=%h/%0d exp=%h/1", data_read, rv_cnt, m_read); end
    checks++; if ((got & mask_of(8)) !== (exp_tx & mask_of(8))) begin failures++; $display("FAIL busy_conf_miso got=%h exp=%h", got, exp_tx & mask_of(8)); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] exp_tx, got; logic exp_ur;
    write_conf(16'h1F07); load_word(32'hDEAD_BEEF); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(32, 32'h0F0F_1234, 10, 2, -1, 16'h0000, got);
    checks++; if (miso !== 1'b1 || data_read !== 32'h0) begin failures++; $display("FAIL rstmid_out got=%b/%h exp=1/00000000", miso, data_read); end
    checks++; if ({read_valid, busy, frame_error, tx_underrun} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_flags got=%b exp=0000", {read_valid, busy, frame_error, tx_underrun});
    end
    tick(2); reset = 1'b0; cs = 1'b1; tick(4);
    m_conf = 16'h0; m_pending = 1'b0; m_read = 32'h0;
    checks++; if (fe_cnt !== 0 || rv_cnt !== 0) begin failures++; $display("FAIL rstmid_pulses got=%0d/%0d exp=0/0", fe_cnt, rv_cnt); end
    write_conf(16'h1F07); load_word(32'hDEAD_BEEF); model_start(exp_tx, exp_ur); clr_cnt();
    run_frame(32, 32'hDEAD_BEEF, -1, 0, -1, 16'h0000, got);
    m_read = 32'hDEAD_BEEF;
    checks++; if (data_read !== m_read || rv_cnt !== 1) begin failures++; $display("FAIL rstmid_next got=%h/%0d exp=%h/1", data_read, rv_cnt, m_read); end
    checks++; if (got !== exp_tx) begin failures++; $display("FAIL rstmid_miso got=%h exp=%h", got, exp_tx); end
  endtask

  task automatic test_random;
    logic [31:0] exp_tx, got, word; logic exp_ur; logic [15:0] c; int n;
    for (int k = 0; k < 8; k++) begin
      c[15:8] = 8'($urandom_range(0, 40));
      c[7:4]  = 4'($urandom);
      c[3:1]  = 3'($urandom);
      c[0]    = 1'b1;
      n = n_of(c);
      word = $urandom;
      write_conf(c);
      if ($urandom_range(0, 3) != 0) load_word($urandom);
      model_start(exp_tx, exp_ur); clr_cnt();
      run_frame(n, word, -1, 0, -1, 16'h0000, got);
      m_read = word & mask_of(n);
      checks++; if (data_read !== m_read || rv_cnt !== 1) begin failures++; $display("FAIL rand_rx[%0d] conf=%h got=%h/%0d exp=%h/1", k, c, data_read, rv_cnt, m_read); end
      checks++; if ((got & mask_of(n)) !== (exp_tx & mask_of(n))) begin failures++; $display("FAIL rand_miso[%0d] conf=%h got=%h exp=%h", k, c, got & mask_of(n), exp_tx & mask_of(n)); end
      checks++; if (ur_cnt !== int'(exp_ur) || busy_seen !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL rand_flags[%0d] ur=%0d busy=%b%b exp ur=%0d busy=10", k, ur_cnt, busy_seen, busy, exp_ur);
      end
    end
  endtask

  initial begin
    reset = 1'b0; sck = 1'b0; cs = 1'b1; mosi = 1'b0;
    data_config = 16'h0; config_enable = 1'b0; data_send = 32'h0; load_data = 1'b0;
    clr_cnt(); busy_seen = 1'b0;
    m_conf = 16'h0; m_pending = 1'b0; m_hold = 32'h0; m_read = 32'h0;
    #1;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_underrun();
    test_frame_error();
    test_conf_busy();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the far end of the team's SPI master link.
- Oversamples the external SCK, CS and MOSI on the system clock CLK and deserialises MOSI into a parallel word.
- Serialises a preloaded parallel word onto MISO.
- Uses a 16-bit config word whose bit layout matches the master's, so one config value drives both ends.

Parameters:
DATA_W, 32, maximum frame length in bits; width of the TX and RX data words.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
SCK  input  1  SPI clock from the master; asynchronous to CLK.
CS  input  1  chip select from the master; asynchronous; polarity set by conf[3].
MOSI  input  1  serial data from the master; asynchronous.
MISO  output  1  serial data to the master.
data_config  input  16  configuration word.
config_enable  input  1  loads data_config into the internal conf register.
data_send  input  DATA_W  word to transmit in the next frame.
load_data  input  1  one-cycle strobe; captures data_send into the TX holding register.
data_read  output  DATA_W  last completed received word.
read_valid  output  1  one-cycle pulse when data_read updates.
busy  output  1  high while a frame is in progress (ACTIVE or DONE).
frame_error  output  1  one-cycle pulse when CS releases mid-frame.
tx_underrun  output  1  one-cycle pulse when a frame starts with no pending TX data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports CLK, reset).
- Reset values: MISO=1, data_read=0, read_valid=0, busy=0, frame_error=0, tx_underrun=0, conf=0, tx_pending=0, state=IDLE.
- conf fields:
  - [0] enable.
  - [1] CPOL: 1 = SCK idles low.
  - [2] order: 1 = MSB first, 0 = LSB first.
  - [3] CS polarity: 1 = active high, 0 = active low.
  - [15:8] frame length minus one. N = conf[15:8]+1, clamped to DATA_W.
  - [7:4] are ignored.
- conf write: on config_enable when busy=0. A write while busy=1 is dropped.
- Synchronisation: SCK, CS and MOSI each pass through 2 flops; edges are detected on the synchronised values.
  - Pin-to-detection latency is 3 CLK.
  - Requirement on the master: SCK high and low times of at least 4 CLK each.
- Timing mode (fixed): sample MOSI on the SCK leading edge of the active-level pulse; shift MISO on the trailing edge.
  - Leading edge = rising when CPOL idles low, falling otherwise.
- TX holding register:
  - load_data sets tx_pending=1 and captures data_send, in any state.
  - A capture during a frame affects only the next frame.
- State machine IDLE / ACTIVE / DONE:
  - IDLE -> ACTIVE on the synchronised CS assert edge.
    - Shift register <= holding register if tx_pending, else all ones with a tx_underrun pulse.
    - tx_pending <= 0, bit count <= 0, busy <= 1.
    - MISO <= first bit in the same cycle: data[N-1] if MSB first, data[0] if LSB first.
  - ACTIVE, leading edge: shift in the synchronised MOSI; count++.
    - When count reaches N: data_read <= received word, read_valid=1 for one cycle, go to DONE.
  - ACTIVE, trailing edge with 0 < count < N: present the next TX bit on MISO.
  - DONE: further SCK edges are ignored; MISO=1.
    - CS release -> IDLE, busy <= 0.
  - ACTIVE, CS release before N bits: frame_error pulse; data_read unchanged; MISO=1; go to IDLE.
  - conf[0]=0 in any state: forced to IDLE within 1 cycle, MISO=1, busy=0, no pulses.
- RX alignment:
  - MSB first: word right-justified in data_read[N-1:0], upper bits 0.
  - LSB first: first received bit lands in data_read[0], word in [N-1:0], upper bits 0.
- Simultaneous read_valid and load_data: both take effect.
- Reset mid-frame: everything returns to reset values immediately; no pulses.

Test Plan:
1. conf=16'h0F07 (N=16, MSB first, CS active low, SCK idle low); data_send=16'hA55A loaded; master sends 16'h1234 at SCK period 10 CLK -> MISO carries A55A MSB first; data_read=32'h00001234; one read_valid pulse; busy falls after CS releases.
2. conf=16'h0703 (N=8, LSB first, SCK idle low); data_send=8'h81; master sends 8'hC3 LSB first -> MISO bits 1,0,0,0,0,0,0,1; data_read=32'h000000C3.
3. Frame started with no load_data -> tx_underrun pulse; MISO constant 1 for all 16 bits; RX still completes normally.
4. CS released after 5 of 16 bits -> frame_error pulse; no read_valid; data_read keeps the previous value; next frame receives correctly.
5. config_enable with a new N asserted mid-frame -> ignored; the current frame completes at the old N; a write after busy falls takes effect.
6. reset asserted mid-frame, then a new frame with 32'hDEADBEEF (N=32) -> outputs return to reset values at once; the following frame returns data_read=32'hDEADBEEF.
